tone_sweep_seq: RTL
===================

Name: tone_sweep_seq

Overview:
- Programmable frequency-sweep sequencer for sound effects (laser, siren, explosion chirps).
- Sits directly upstream of audio_note and drives its 24-bit frequency input.
- Replaces the hard-wired ramp counter: software or game logic loads start/end/step/rate/repeat, pulses start, and the block walks o_freq from start to end at a timed rate.
- Reports busy and done status; o_gate can mute the audio output when idle.

Parameters:
- FREQ_W, 24, width of frequency values; matches the audio_note frequency input.
- STEP_W, 16, width of the per-step frequency increment.
- TICK_DIV, 12000, i_clk cycles per base tick (1 ms at 12 MHz); must be >= 2.
- RATE_W, 8, width of the ticks-per-step field.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  synchronous, active-low reset.
- i_start  in  1  start request; sampled every cycle.
- i_stop  in  1  abort request; sampled every cycle.
- i_start_freq  in  FREQ_W  first frequency of the sweep.
- i_end_freq  in  FREQ_W  final frequency of the sweep.
- i_step  in  STEP_W  magnitude of the frequency change per step.
- i_rate  in  RATE_W  base ticks per step.
- i_repeat  in  4  extra passes after the first pass.
- o_freq  out  FREQ_W  frequency to audio_note.
- o_gate  out  1  high while a sweep is active.
- o_busy  out  1  high while not IDLE.
- o_done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset: i_rst_n low at a rising edge of i_clk forces IDLE on the next cycle. Outputs then read o_freq=0, o_gate=0, o_busy=0, o_done=0. All counters clear. Reset is honoured mid-sweep.
- States: IDLE and SWEEP. o_done is a registered pulse, not a state.
- Accept: IDLE & i_start & !i_stop at cycle N.
  - Latch all config inputs.
  - dir_up = (end >= start).
  - eff_step = max(i_step, 1); eff_rate = max(i_rate, 1).
  - Remaining repeats = i_repeat.
  - Prescaler and rate counters cleared to 0.
  - At N+1: state is SWEEP, o_freq=start, o_gate=1, o_busy=1.
- Config inputs are ignored after acceptance. i_start is ignored while in SWEEP; there is no restart.
- Prescaler:
  - Counts 0..TICK_DIV-1 in SWEEP and wraps.
  - tick = (count == TICK_DIV-1).
  - The rate counter advances on each tick and wraps at eff_rate-1.
  - step_evt = tick & (rate count == eff_rate-1).
  - First step_evt occurs at cycle N + eff_rate*TICK_DIV. The new value is visible one cycle later.
- On step_evt:
  - If o_freq != end:
    - Up: o_freq <= min(o_freq + eff_step, end).
    - Down: o_freq <= max(o_freq - eff_step, end).
    - Compute in FREQ_W+1 bits so an overflow or underflow clamps to end. There is no wrap-around.
  - Else if remaining repeats > 0: o_freq <= start; decrement remaining repeats.
  - Else: go to IDLE. Next cycle: o_done=1 for exactly one cycle, o_freq=0, o_gate=0, o_busy=0.
- The end value is therefore held for one full step period before a reload or finish.
- start == end: the block holds that value for one step period per pass, then finishes.
- Abort: i_stop in SWEEP → IDLE next cycle, with outputs at their reset values and no o_done pulse.
  - i_stop has priority over i_start and over a coincident step_evt.
- Accept in the cycle o_done is high: allowed. A new i_start is accepted in any IDLE cycle, including the o_done cycle.

Test Plan (TICK_DIV=4 overridden in bench):
- Up sweep, no repeats.
  - Stimulus: start=100, end=700, step=100, rate=1, repeat=0; accept at N.
  - Required response: o_freq=100 from N+1, 200 at N+5, then +100 every 4 cycles, reaching 700 at N+25.
  - At N+29: o_done pulse, o_busy=0, o_gate=0, o_freq=0.
- Down sweep with clamping.
  - Stimulus: start=500, end=130, step=100, rate=2.
  - Required response: o_freq sequence 500, 400, 300, 200, 130, each held 8 cycles. o_done at N+41.
- Repeats.
  - Stimulus: same config as the up sweep, with repeat=1.
  - Required response: o_freq reloads 100 at N+29, the second pass ends at 700, and a single o_done arrives at N+57.
- Zero fields and overflow.
  - Stimulus: step=0, rate=0, start=0xFFFFF0, end=0xFFFFFF.
  - Required response: step treated as 1 and rate as 1. o_freq reaches 0xFFFFFF after 15 steps with no wrap.
  - Separately, start=end=300: o_freq=300 for 4 cycles, then done.
- Abort and reset.
  - Stimulus: i_stop at N+10 during the up sweep.
  - Required response: idle outputs at N+11, no o_done.
  - Stimulus: i_rst_n low at N+10 in a repeated sweep.
  - Required response: all outputs 0 at N+11, and the next accepted start behaves as from reset.
- Handshake corner cases.
  - Stimulus: i_start pulsed during SWEEP with a different config.
  - Required response: ignored; the sweep is unchanged.
  - Stimulus: i_start and i_stop together in IDLE.
  - Required response: not accepted.
  - Stimulus: i_start asserted in the o_done cycle.
  - Required response: accepted; o_busy=1 on the following cycle.

Source files
------------

// File: rtl/tone_sweep_seq.sv
// Frequency-sweep sequencer feeding audio_note: walks o_freq from a start to an
// end frequency in fixed steps at a programmable tick rate, with optional repeat passes.
module tone_sweep_seq #(
  parameter int FREQ_W   = 24,
  parameter int STEP_W   = 16,
  parameter int TICK_DIV = 12000,
  parameter int RATE_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [FREQ_W-1:0] i_start_freq,
  input  logic [FREQ_W-1:0] i_end_freq,
  input  logic [STEP_W-1:0] i_step,
  input  logic [RATE_W-1:0] i_rate,
  input  logic [3:0]        i_repeat,
  output logic [FREQ_W-1:0] o_freq,
  output logic              o_gate,
  output logic              o_busy,
  output logic              o_done
);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state, state_nxt;

  logic [FREQ_W-1:0] freq, start_q, end_q, next_freq;
  logic [STEP_W-1:0] step_q;
  logic [RATE_W-1:0] rate_q, rcnt;
  logic [3:0]        rep;
  logic              dir_up, done;
  logic [PW-1:0]     presc;
  logic              accept, finish, tick, rate_wrap, step_evt, at_end;
  logic [FREQ_W:0]   sum, diff;

  assign tick      = (presc == PW'(TICK_DIV - 1));
  assign rate_wrap = (rcnt == rate_q - RATE_W'(1));
  assign step_evt  = (state == SWEEP) && tick && rate_wrap;
  assign at_end    = (freq == end_q);

  // One extra bit so a step past either rail clamps to the end value instead of wrapping.
  always_comb begin
    sum  = {1'b0, freq} + (FREQ_W+1)'(step_q);
    diff = {1'b0, freq} - (FREQ_W+1)'(step_q);
    next_freq = end_q;
    if (dir_up) begin
      if (sum <= {1'b0, end_q}) next_freq = sum[FREQ_W-1:0];
    end else begin
      if (!diff[FREQ_W] && diff >= {1'b0, end_q}) next_freq = diff[FREQ_W-1:0];
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: if (i_start && !i_stop) begin
        accept    = 1'b1;
        state_nxt = SWEEP;
      end
      SWEEP: if (i_stop) begin
        state_nxt = IDLE;
      end else if (step_evt && at_end && rep == 4'd0) begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      freq    <= '0;
      start_q <= '0;
      end_q   <= '0;
      step_q  <= '0;
      rate_q  <= '0;
      rep     <= '0;
      dir_up  <= 1'b0;
      presc   <= '0;
      rcnt    <= '0;
      done    <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        freq    <= i_start_freq;
        start_q <= i_start_freq;
        end_q   <= i_end_freq;
        step_q  <= (i_step == '0) ? STEP_W'(1) : i_step;
        rate_q  <= (i_rate == '0) ? RATE_W'(1) : i_rate;
        rep     <= i_repeat;
        dir_up  <= (i_end_freq >= i_start_freq);
        presc   <= '0;
        rcnt    <= '0;
      end else if (state == SWEEP && state_nxt == IDLE) begin
        // Abort or completion: outputs return to their idle values.
        freq  <= '0;
        presc <= '0;
        rcnt  <= '0;
        rep   <= '0;
      end else if (state == SWEEP) begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick) rcnt <= rate_wrap ? '0 : rcnt + RATE_W'(1);
        if (step_evt) begin
          if (!at_end) begin
            freq <= next_freq;
          end else if (rep != 4'd0) begin
            freq <= start_q;
            rep  <= rep - 4'd1;
          end
        end
      end
    end
  end

  assign o_freq = freq;
  assign o_gate = (state == SWEEP);
  assign o_busy = (state == SWEEP);
  assign o_done = done;
endmodule
